mywatch_stopwatch: RTL

Stopwatch core for the MyWatch design, sitting downstream of the 100 Hz divider. It takes the divider's 100 Hz square wave as a plain input level, detects its rising edges in the CLOCK domain, and counts in packed BCD: centiseconds, seconds and minutes. It also handles start/stop, clear and lap-hold keys, and drives the digit values the display mux consumes.

---
 rtl/mywatch_pkg.sv | 56 +++++
 rtl/mywatch_stopwatch_sync_rise_det.sv | 30 +++
 rtl/mywatch_stopwatch.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/mywatch_pkg.sv
// Shared types and constants for the MyWatch stopwatch core.
package mywatch_pkg;

    // Width of one BCD digit.
    localparam int DIGIT_W = 4;

    // Counting limits, expressed as two-digit decimal values.
    localparam int CS_MAX  = 99;
    localparam int SEC_MAX = 59;
    localparam int MIN_MAX = 59;

    typedef logic [DIGIT_W-1:0] digit_t;
    typedef logic [2*DIGIT_W-1:0] bcd2_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    // Full six-digit count, most significant digit first.
    typedef struct packed {
        digit_t min_t;
        digit_t min_o;
        digit_t sec_t;
        digit_t sec_o;
        digit_t cs_t;
        digit_t cs_o;
    } count_t;

    // Result of incrementing one two-digit field.
    typedef struct packed {
        logic  wrap;
        bcd2_t val;
    } inc2_t;

    // Increment a packed two-digit BCD field that wraps to 00 after max.
    function automatic inc2_t bcd2_inc(input bcd2_t v, input int max);
        inc2_t  r;
        digit_t tens;
        digit_t ones;
        tens   = v[2*DIGIT_W-1:DIGIT_W];
        ones   = v[DIGIT_W-1:0];
        r.wrap = 1'b0;
        if (tens == digit_t'(max / 10) && ones == digit_t'(max % 10)) begin
            r.val  = '0;
            r.wrap = 1'b1;
        end else if (ones >= digit_t'(9)) begin
            r.val = {tens + digit_t'(1), digit_t'(0)};
        end else begin
            r.val = {tens, ones + digit_t'(1)};
        end
        return r;
    endfunction

endpackage

// File: rtl/mywatch_stopwatch_sync_rise_det.sv
// Two-flop synchronizer followed by a one-cycle rising-edge detector.
module sync_rise_det (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    // Synchronize the asynchronous level and keep its previous value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge value, forming a true shift chain.
            meta_q <= din;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    // High for exactly one cycle per synchronized 0->1 transition.
    assign rise = sync_q & ~prev_q;

endmodule

// File: rtl/mywatch_stopwatch.sv
// Stopwatch core: key/tick conditioning, run/pause FSM, BCD count with
// carry chain, lap snapshot and registered display outputs.
module mywatch_stopwatch
    import mywatch_pkg::*;
(
    input  logic       CLOCK,
    input  logic       RESET,
    input  logic       tick_in,
    input  logic       key_start_stop,
    input  logic       key_clear,
    input  logic       key_lap,
    output logic [7:0] cs_bcd,
    output logic [7:0] sec_bcd,
    output logic [7:0] min_bcd,
    output logic       running,
    output logic       lap_held,
    output logic       overflow
);

    // Conditioned one-cycle event pulses.
    logic tick_p;
    logic ss_p;
    logic clr_p;
    logic lap_p;

    sync_rise_det u_tick (.clk(CLOCK), .rst(RESET), .din(tick_in),        .rise(tick_p));
    sync_rise_det u_ss   (.clk(CLOCK), .rst(RESET), .din(key_start_stop), .rise(ss_p));
    sync_rise_det u_clr  (.clk(CLOCK), .rst(RESET), .din(key_clear),      .rise(clr_p));
    sync_rise_det u_lap  (.clk(CLOCK), .rst(RESET), .din(key_lap),        .rise(lap_p));

    state_t state_q;
    state_t state_d;

    logic   count_en;
    logic   lap_toggle;
    logic   lap_force_off;

    count_t cnt_q;
    count_t cnt_d;
    count_t snap_q;
    count_t snap_d;
    count_t disp_d;
    logic   wrap;
    logic   lap_d;
    logic   ovf_d;

    inc2_t  cs_inc;
    inc2_t  sec_inc;
    inc2_t  min_inc;

    // FSM state register.
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: clear wins over start/stop.
    always_comb begin
        // NOTE: default assignment first so no path through this block leaves state_d unassigned (no latch).
        state_d = state_q;
        if (clr_p) begin
            state_d = IDLE;
        end else if (ss_p) begin
            unique case (state_q)
                IDLE:    state_d = RUN;
                RUN:     state_d = PAUSE;
                PAUSE:   state_d = RUN;
                default: state_d = IDLE;
            endcase
        end
    end

    // FSM control outputs, judged by the current state and same-cycle priority.
    always_comb begin
        count_en      = 1'b0;
        lap_toggle    = 1'b0;
        lap_force_off = 1'b0;
        if (!clr_p) begin
            // A tick in RUN counts even when start/stop moves us to PAUSE.
            count_en = tick_p && (state_q == RUN);
            if (lap_p && !ss_p) begin
                if (state_q == RUN) begin
                    lap_toggle = 1'b1;
                end else begin
                    lap_force_off = 1'b1;
                end
            end
        end
    end

    // Six-digit BCD carry chain; wraps 59:59.99 to 00:00.00.
    always_comb begin
        cs_inc  = bcd2_inc({cnt_q.cs_t,  cnt_q.cs_o},  CS_MAX);
        sec_inc = bcd2_inc({cnt_q.sec_t, cnt_q.sec_o}, SEC_MAX);
        min_inc = bcd2_inc({cnt_q.min_t, cnt_q.min_o}, MIN_MAX);
        cnt_d   = cnt_q;
        wrap    = 1'b0;
        if (clr_p) begin
            cnt_d = '0;
        end else if (count_en) begin
            {cnt_d.cs_t, cnt_d.cs_o} = cs_inc.val;
            if (cs_inc.wrap) begin
                {cnt_d.sec_t, cnt_d.sec_o} = sec_inc.val;
                if (sec_inc.wrap) begin
                    {cnt_d.min_t, cnt_d.min_o} = min_inc.val;
                    wrap = min_inc.wrap;
                end
            end
        end
    end

    // Lap hold, snapshot capture, sticky overflow and displayed value.
    always_comb begin
        lap_d  = lap_held;
        snap_d = snap_q;
        if (clr_p) begin
            lap_d = 1'b0;
        end else if (lap_toggle) begin
            lap_d = ~lap_held;
        end else if (lap_force_off) begin
            lap_d = 1'b0;
        end
        // Snapshot takes the value the live count lands on at the freeze edge.
        if (lap_d && !lap_held) begin
            snap_d = cnt_d;
        end
        ovf_d  = clr_p ? 1'b0 : (overflow | wrap);
        disp_d = lap_d ? snap_d : cnt_d;
    end

    // Count, snapshot and flag registers.
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            cnt_q    <= '0;
            snap_q   <= '0;
            lap_held <= 1'b0;
            overflow <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            snap_q   <= snap_d;
            lap_held <= lap_d;
            overflow <= ovf_d;
        end
    end

    // Registered display outputs, aligned with the state/count update.
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            cs_bcd  <= 8'h00;
            sec_bcd <= 8'h00;
            min_bcd <= 8'h00;
            running <= 1'b0;
        end else begin
            cs_bcd  <= {disp_d.cs_t,  disp_d.cs_o};
            sec_bcd <= {disp_d.sec_t, disp_d.sec_o};
            min_bcd <= {disp_d.min_t, disp_d.min_o};
            running <= (state_d == RUN);
        end
    end

endmodule
